// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer.
//   - state_e            : sequencer state (OFF, RAMP, RUN, STOP)
//   - *_DEF              : default parameter values for the 10-step datapath
//   - sat_inc / sat_dec  : saturating duty/target arithmetic
package pwm_pkg;

    localparam int DUTY_MAX_DEF  = 10;
    localparam int DUTY_W_DEF    = 4;
    localparam int DUTY_INIT_DEF = 5;
    localparam int STEP_DIV_DEF  = 4;

    // Working width of the saturating helpers; callers zero-extend into it
    // and truncate back, so any DUTY_W up to SAT_W is supported.
    localparam int SAT_W = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    // +1 clamped at lim; the compare happens before the add so it never wraps.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] lim);
        return (v >= lim) ? lim : v + SAT_W'(1);
    endfunction

    // -1 clamped at 0.
    function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] v);
        return (v == '0) ? '0 : v - SAT_W'(1);
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Host target-load channel of the duty sequencer.
//   tgt_valid   host -> seq   load request
//   tgt_data    host -> seq   requested target code
//   tgt_ready   seq  -> host  load accepted when tgt_valid & tgt_ready
//   tgt_clamped seq  -> host  one-cycle pulse: accepted value exceeded DUTY_MAX
interface pwm_duty_sequencer_if
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
);
    logic              tgt_valid;
    logic [DUTY_W-1:0] tgt_data;
    logic              tgt_ready;
    logic              tgt_clamped;

    modport master (output tgt_valid, output tgt_data,
                    input  tgt_ready, input  tgt_clamped);

    modport slave  (input  tgt_valid, input  tgt_data,
                    output tgt_ready, output tgt_clamped);
endinterface

// File: rtl/pwm_step_timer.sv
// Ramp step prescaler: counts PWM period_end pulses and issues one tick
// every STEP_DIV periods.
//   clk, rst_n    clock, async active-low reset
//   period_end_i  one-cycle pulse on the last count of a PWM period
//   clr_i         restart the count (state entry); a coincident period_end
//                 is discarded and produces no tick
//   tick_o        combinational: this period_end completes a step
module pwm_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic period_end_i,
    input  logic clr_i,
    output logic tick_o
);
    // STEP_DIV=1 still needs a 1-bit counter that simply stays at 0.
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             last;

    assign last   = (step_cnt_q == CNT_LAST);
    assign tick_o = period_end_i & last & ~clr_i;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (clr_i)
            step_cnt_d = '0;
        else if (period_end_i)
            step_cnt_d = last ? '0 : step_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_cnt_q <= '0;
        else
            step_cnt_q <= step_cnt_d;
    end
endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle setpoint controller for the PWM datapath.
// Merges debounced inc/dec pulses and host target loads into one target and
// ramps the applied duty toward it one code per step tick, so duty only ever
// changes on the first cycle of a PWM period.
//   clk, rst_n   clock, async active-low reset
//   enable       1 = run, 0 = soft-stop (ramp duty down to 0, then OFF)
//   period_end   one-cycle pulse on the PWM counter's last count
//   inc_pulse    target +1 (saturating)
//   dec_pulse    target -1 (saturating)
//   host         target-load channel (slave side)
//   duty         applied duty code
//   pwm_en       PWM output gate (RAMP/RUN/STOP)
//   busy         ramp or stop in progress
//   at_target    duty equals target while in RUN
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_MAX  = DUTY_MAX_DEF,
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int DUTY_INIT = DUTY_INIT_DEF,
    parameter int STEP_DIV  = STEP_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                period_end,
    input  logic                inc_pulse,
    input  logic                dec_pulse,
    pwm_duty_sequencer_if.slave host,
    output logic [DUTY_W-1:0]   duty,
    output logic                pwm_en,
    output logic                busy,
    output logic                at_target
);
    localparam logic [DUTY_W-1:0] MAX_C = DUTY_W'(DUTY_MAX);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              clamp_q, clamp_d;
    logic              pwm_en_q, busy_q, at_tgt_q, ready_q;
    logic              step_clr, tick, accept;

    assign accept = host.tgt_valid & ready_q;

    // Target arbitration: host load > inc > dec; inc together with dec
    // cancels. Frozen while stopping (the host is also stalled then).
    always_comb begin
        target_d = target_q;
        clamp_d  = 1'b0;
        if (state_q != ST_STOP) begin
            if (accept) begin
                if (host.tgt_data > MAX_C) begin
                    target_d = MAX_C;
                    clamp_d  = 1'b1;
                end else begin
                    target_d = host.tgt_data;
                end
            end else if (inc_pulse && !dec_pulse) begin
                target_d = DUTY_W'(sat_inc(SAT_W'(target_q), SAT_W'(DUTY_MAX)));
            end else if (dec_pulse && !inc_pulse) begin
                target_d = DUTY_W'(sat_dec(SAT_W'(target_q)));
            end
        end
    end

    // Next state. Independent of the tick, so the step timer clear can be
    // derived from it without a combinational loop. Disable beats the
    // duty/target comparison.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (enable) state_d = ST_RAMP;
            ST_RAMP: if (!enable)                 state_d = ST_STOP;
                     else if (duty_q == target_q) state_d = ST_RUN;
            ST_RUN:  if (!enable)                 state_d = ST_STOP;
                     else if (duty_q != target_q) state_d = ST_RAMP;
            ST_STOP: if (enable)                  state_d = ST_RAMP;
                     else if (duty_q == '0)       state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase
    end

    // Every entry into RAMP or STOP restarts the step count.
    assign step_clr = (state_d != state_q) &&
                      ((state_d == ST_RAMP) || (state_d == ST_STOP));

    // Duty moves only on a tick and only while the state holds; the
    // direction is re-evaluated each tick so mid-ramp target changes are
    // followed.
    always_comb begin
        duty_d = duty_q;
        if (tick && (state_d == state_q)) begin
            if (state_q == ST_RAMP)
                duty_d = (target_q > duty_q)
                       ? DUTY_W'(sat_inc(SAT_W'(duty_q), SAT_W'(DUTY_MAX)))
                       : DUTY_W'(sat_dec(SAT_W'(duty_q)));
            else if (state_q == ST_STOP)
                duty_d = DUTY_W'(sat_dec(SAT_W'(duty_q)));
        end
        if (state_q == ST_OFF)
            duty_d = '0;
    end

    // State, datapath and status outputs; status is decoded from the next
    // state so it is registered yet aligned with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            duty_q   <= '0;
            target_q <= DUTY_W'(DUTY_INIT);
            clamp_q  <= 1'b0;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
            at_tgt_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            clamp_q  <= clamp_d;
            pwm_en_q <= (state_d != ST_OFF);
            busy_q   <= (state_d == ST_RAMP) || (state_d == ST_STOP);
            at_tgt_q <= (state_d == ST_RUN);
            ready_q  <= (state_d != ST_STOP);
        end
    end

    pwm_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .period_end_i (period_end),
        .clr_i        (step_clr),
        .tick_o       (tick)
    );

    assign duty             = duty_q;
    assign pwm_en           = pwm_en_q;
    assign busy             = busy_q;
    assign at_target        = at_tgt_q;
    assign host.tgt_ready   = ready_q;
    assign host.tgt_clamped = clamp_q;
endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Controller that owns the duty-cycle setpoint of the 10-step PWM datapath.
- Merges debounced inc/dec button pulses and a host valid/ready target load into one target.
- Ramps the applied duty toward that target at a programmable rate (soft-start/soft-stop).
- Changes the applied duty only on PWM period boundaries, so no PWM period sees a mid-period duty change.
- Sits between the debounce stage/host and the PWM counter/comparator.

Parameters:
- DUTY_MAX, 10: maximum duty code (100%); the PWM period is DUTY_MAX counts.
- DUTY_W, 4: duty width; must satisfy 2^DUTY_W > DUTY_MAX.
- DUTY_INIT, 5: target value after reset.
- STEP_DIV, 4: number of period_end pulses per one-code ramp step (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run PWM, 0 = soft-stop.
- period_end  in  1  one-cycle pulse from PWM counter on its last count (counter==DUTY_MAX-1).
- inc_pulse  in  1  debounced one-cycle request, target +1.
- dec_pulse  in  1  debounced one-cycle request, target -1.
- tgt_valid  in  1  host target load valid.
- tgt_data  in  DUTY_W  host target value.
- tgt_ready  out  1  host load accepted when tgt_valid & tgt_ready.
- duty  out  DUTY_W  applied duty code to the PWM comparator.
- pwm_en  out  1  gates the PWM output.
- busy  out  1  ramp or stop in progress.
- at_target  out  1  duty equals target in RUN.
- tgt_clamped  out  1  one-cycle pulse: an accepted host value exceeded DUTY_MAX.

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=OFF, duty=0, target=DUTY_INIT, step_cnt=0.
  - pwm_en=0, busy=0, at_target=0, tgt_ready=1, tgt_clamped=0.
- States: OFF, RAMP, RUN, STOP.
- Output decode:
  - pwm_en=1 in RAMP/RUN/STOP.
  - busy=1 in RAMP/STOP.
  - at_target=1 only in RUN.
  - tgt_ready=0 only in STOP.
- Target update (every cycle, all states except STOP):
  - Priority: host load > inc > dec.
  - Host load: target <= min(tgt_data, DUTY_MAX); tgt_clamped pulses next cycle if tgt_data > DUTY_MAX.
  - inc: target+1, saturating at DUTY_MAX. dec: target-1, saturating at 0.
  - inc & dec in the same cycle without a host load: both ignored.
  - Button pulses during a host load are dropped.
  - In STOP: target frozen, buttons ignored, host stalled by tgt_ready=0.
- Step tick:
  - step_cnt counts period_end pulses; tick = period_end & (step_cnt==STEP_DIV-1), then step_cnt wraps to 0.
  - step_cnt is cleared on every transition into RAMP or STOP.
  - duty changes only on a tick; the new value is visible the cycle after the tick (first cycle of the next PWM period).
- Transitions:
  - OFF -> RAMP when enable=1. duty starts from 0.
  - RAMP: on each tick, duty moves one code toward target; direction re-evaluated every tick, so mid-ramp target changes are followed.
  - RAMP -> RUN in the cycle after duty==target (no tick needed).
  - RUN -> RAMP when target != duty.
  - RAMP/RUN -> STOP when enable=0; takes priority over the target comparison.
  - STOP: on each tick, duty-1; when duty==0 -> OFF.
  - STOP -> RAMP when enable returns to 1; ramp resumes from the current duty.
  - OFF with enable=0 stays OFF; host/buttons may preset target.
- Boundaries:
  - target=0 in RAMP: ramps down to 0 and stays in RUN with pwm_en=1 (output constant low).
  - STEP_DIV=1: one step per PWM period.
  - period_end in the same cycle as a state entry does not count.
- Arithmetic: all duty/target math is DUTY_W unsigned; no wrap is permitted (saturate before add/sub).

Decomposition:
- Shared package pwm_pkg:
  - state enum (OFF, RAMP, RUN, STOP).
  - DUTY_MAX/DUTY_W defaults.
  - saturating inc/dec functions.
- One sub-module, pwm_step_timer: step_cnt, clear input, tick output.
- Target arbitration and the FSM stay in the top module.

Test Plan:
(period_end every 10 clk, STEP_DIV=2, DUTY_INIT=5)
- Reset then enable=1 -> duty steps 0,1,...,5, one step per 20 clk after the first tick; RUN with at_target=1 after duty==5; pwm_en=1 from the cycle after enable.
- In RUN at 5, host load tgt_data=13 -> target=10, tgt_clamped pulses once; duty ramps to 10, then RUN.
- In RUN at 10: inc_pulse -> target stays 10. inc & dec in the same cycle -> no change. dec_pulse -> duty 9 after one step.
- enable=0 at duty=6 -> STOP, tgt_ready=0; duty 6->0 over 6 ticks, then OFF, pwm_en=0. Host tgt_valid held during STOP is accepted only after OFF.
- During RAMP 0->8, at duty=3 load target=1 -> duty reverses to 2, then 1, then RUN; every duty change coincides with the cycle after period_end.
- rst_n low mid-RAMP at duty=4 -> duty=0, state OFF, target=5 immediately (asynchronous); on release with enable=1, ramp restarts from 0.
